// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : debounce_sync
// Brief    : Synchronizes a raw asynchronous input and debounces it into a
//            clean level. The sig_clean level changes only after the
//            synchronized input has held a new value for DEBOUNCE_CYCLES
//            consecutive samples.
// Option   : DEBOUNCE_GLITCH_CNT_EN adds a saturating glitch_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig_raw,
    output logic                sig_clean,
    output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || GLITCH_W < 1) begin : g_param_check
        $error("debounce_sync: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_clean;
    logic                   r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_raw};
        end
    end

    assign w_s_sync = r_sync[SYNC_STAGES-1];

    // The qualifying sample that enters a CHECK state counts as the first one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                STABLE_LOW: begin
                    if (w_s_sync) begin
                        r_state <= CHECK_HIGH;
                        r_cnt   <= C_CNT_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                CHECK_HIGH: begin
                    if (!w_s_sync) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                        r_clean <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!w_s_sync) begin
                        r_state <= CHECK_LOW;
                        r_cnt   <= C_CNT_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                CHECK_LOW: begin
                    if (w_s_sync) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                        r_clean <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= STABLE_LOW;
                    r_cnt   <= '0;
                    r_clean <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sig_clean = r_clean;
    assign busy      = r_busy;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                w_abort;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    assign w_abort = ((r_state == CHECK_HIGH) && !w_s_sync) ||
                     ((r_state == CHECK_LOW)  &&  w_s_sync);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= '0;
        end else if (w_abort && (r_glitch_cnt != {GLITCH_W{1'b1}})) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_sync
// Brief    : Directed self-checking bench for debounce_sync (2 sync stages,
//            4 debounce cycles); glitch counter checked when enabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig_raw;
    logic       sig_clean;
    logic       busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    always #5 clk = ~clk;

    debounce_sync #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .GLITCH_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_raw   (sig_raw),
        .sig_clean (sig_clean),
        .busy      (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    typedef struct {
        logic  clean;
        logic  bsy;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;

    // Bounce, near-miss expectations (index 0 = first edge after stimulus).
    logic [0:10] t3_raw   = 11'b10110111111;
    logic [0:10] t3_busy  = 11'b00101101110;
    logic [0:10] t3_clean = 11'b00000000001;
    logic [0:9]  t4_raw   = 10'b1110000000;
    logic [0:9]  t4_busy  = 10'b0011100000;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
    task automatic check_glitch(input string tag, input logic [7:0] exp);
        vectors++;
        assert (glitch_cnt === exp) else begin
            miscompares++;
            $error("FAIL %s: observed glitch_cnt %0d expected %0d", tag, glitch_cnt, exp);
        end
    endtask
`endif

    // Drive one cycle, queue its expected outputs, then retire them after the edge.
    task automatic cyc(input logic raw, input logic r, input logic e_clean,
                       input logic e_busy, input string tag);
        exp_t e;
        sig_raw = raw;
        rst     = r;
        e.clean = e_clean;
        e.bsy   = e_busy;
        e.tag   = $sformatf("%s@%0d", tag, cycle);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        e = sb.pop_front();
        check_bit({e.tag, ".sig_clean"}, sig_clean, e.clean);
        check_bit({e.tag, ".busy"}, busy, e.bsy);
    endtask

    // Held step: two sync edges, three CHECK edges, commit on the sixth.
    task automatic step(input logic raw, input logic old_clean, input string tag);
        cyc(raw, 1'b0, old_clean, 1'b0, tag);
        cyc(raw, 1'b0, old_clean, 1'b0, tag);
        for (int i = 0; i < 3; i++) cyc(raw, 1'b0, old_clean, 1'b1, tag);
        cyc(raw, 1'b0, ~old_clean, 1'b0, tag);
    endtask

    task automatic hold(input logic raw, input logic clean, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(raw, 1'b0, clean, 1'b0, tag);
    endtask

    initial begin
        sig_raw = 1'b0;
        rst     = 1'b1;

        // 1: reset with sig_raw high, then release
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, "t1_rst");
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_glitch("t1_rst_glitch", 8'd0);
`endif
        step(1'b1, 1'b0, "t1_rel");
        hold(1'b1, 1'b1, 3, "t1_hold");

        // 2: clean steps both ways
        step(1'b0, 1'b1, "t2_pre");
        hold(1'b0, 1'b0, 3, "t2_low");
        step(1'b1, 1'b0, "t2_rise");
        hold(1'b1, 1'b1, 14, "t2_high");
        step(1'b0, 1'b1, "t2_fall");
        hold(1'b0, 1'b0, 4, "t2_low2");
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_glitch("t2_glitch", 8'd0);
`endif

        // 3: bounce then settle high
        for (int i = 0; i < 11; i++) cyc(t3_raw[i], 1'b0, t3_clean[i], t3_busy[i], "t3_bounce");
        hold(1'b1, 1'b1, 3, "t3_hold");
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_glitch("t3_glitch", 8'd2);
`endif
        step(1'b0, 1'b1, "t3_back");
        hold(1'b0, 1'b0, 2, "t3_low");

        // 4: near-miss, reversal on the final qualifying sample
        for (int i = 0; i < 10; i++) cyc(t4_raw[i], 1'b0, 1'b0, t4_busy[i], "t4_near");
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_glitch("t4_glitch", 8'd3);
`endif

        // 5: reset in the middle of qualification
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t5_pre");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t5_pre");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "t5_chk");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "t5_rst");
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_glitch("t5_glitch_rst", 8'd0);
`endif
        step(1'b1, 1'b0, "t5_rel");
        hold(1'b1, 1'b1, 3, "t5_hold");

        // 6: 300 aborted qualifications from a low level
        step(1'b0, 1'b1, "t6_pre");
        hold(1'b0, 1'b0, 2, "t6_low");
        for (int k = 1; k <= 602; k++) begin
            logic raw_k;
            logic exp_b;
            raw_k = (k <= 600) && (k % 2 == 1);
            exp_b = (k >= 3) && (k - 2 <= 600) && ((k - 2) % 2 == 1);
            cyc(raw_k, 1'b0, 1'b0, exp_b, "t6_toggle");
        end
        hold(1'b0, 1'b0, 3, "t6_tail");
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_glitch("t6_glitch_sat", 8'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw asynchronous input (push-button, switch, external strobe) into a clean, glitch-free, clock-synchronous level.
- Sits directly upstream of the edge detector and drives its sampled-signal input.
- Guarantees the edge detector's input contract: one transition per physical event, no bounces, no metastability.
- Output level changes only after the synchronized input has held a new value for a programmable number of consecutive cycles.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer chain; legal range >= 2.
- DEBOUNCE_CYCLES, 1000, consecutive stable samples required before sig_clean changes; legal range >= 2.
- GLITCH_W, 8, width of the rejected-glitch counter (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous and active-high; sampled on rising clk.
- sig_raw  input  1  raw asynchronous input; may bounce or glitch.
- sig_clean  output  1  debounced, synchronized level; feeds the edge detector.
- busy  output  1  high while a candidate transition is being qualified (CHECK_HIGH or CHECK_LOW).
- glitch_cnt  output  GLITCH_W  saturating count of rejected candidate transitions; present only with DEBOUNCE_GLITCH_CNT_EN.

Behaviour:
- Reset, on a rising clk with rst=1:
  - all synchronizer flops cleared to 0.
  - state goes to STABLE_LOW; stable counter cleared to 0.
  - sig_clean=0, busy=0, glitch_cnt=0.
  - rst overrides every other event in the same cycle.
- Synchronizer:
  - sig_raw passes through a SYNC_STAGES flop chain.
  - The last stage, s_sync, is the only value the FSM reads.
  - No combinational path from sig_raw to any output.
- Stable counter: width $clog2(DEBOUNCE_CYCLES). It must never wrap, because the FSM leaves the CHECK states before the counter exceeds DEBOUNCE_CYCLES-1.
- FSM states: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
  - STABLE_LOW:
    - s_sync=0: stay.
    - s_sync=1: go to CHECK_HIGH with cnt=1; this sample counts as the first.
  - CHECK_HIGH:
    - s_sync=1 and cnt<DEBOUNCE_CYCLES-1: cnt++.
    - s_sync=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HIGH, sig_clean<=1, cnt<=0.
    - s_sync=0: go to STABLE_LOW, cnt<=0, sig_clean stays 0, glitch event.
  - STABLE_HIGH and CHECK_LOW: mirror images of the above (polarity swapped; sig_clean<=0 on qualification).
- Outputs:
  - sig_clean is registered and changes only on the qualification transition.
  - busy is registered: 1 exactly while the state is CHECK_HIGH or CHECK_LOW.
- Latency: a clean step on sig_raw held indefinitely appears on sig_clean exactly SYNC_STAGES + DEBOUNCE_CYCLES rising clk edges after the first edge that samples the new value.
- Boundary conditions:
  - An input toggling faster than DEBOUNCE_CYCLES never changes sig_clean.
  - A reversal on the final qualifying sample aborts qualification: there is no partial commit.
  - Reset during CHECK_* discards qualification.
  - Reset while sig_raw=1: sig_clean stays 0 until SYNC_STAGES + DEBOUNCE_CYCLES edges after rst deasserts. This is the only legal way to produce a rising edge after reset.
  - sig_clean never toggles on two consecutive cycles.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- When defined:
  - glitch_cnt port exists.
  - It increments by 1 on every aborted qualification (CHECK_HIGH->STABLE_LOW or CHECK_LOW->STABLE_HIGH).
  - It saturates at 2^GLITCH_W-1.
  - It is cleared only by rst.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=8):
1. rst=1 for 3 cycles with sig_raw=1, then rst=0 -> sig_clean=0 and busy=0 during reset; sig_clean rises exactly 6 edges after rst deassert; busy high for the 3 preceding cycles.
2. Clean 0->1 step, held 20 cycles -> sig_clean rises at edge 6 after the step; then a 1->0 step -> sig_clean falls at edge 6 after it; glitch_cnt=0.
3. Bounce: sig_raw pattern 1,0,1,1,0,1 (one per cycle), then held 1 -> sig_clean stays 0 until 6 edges after the final 0->1; glitch_cnt=2 with the macro.
4. Near-miss: sig_raw high for exactly 3 cycles, then low -> sig_clean never asserts; busy pulses for 3 cycles; glitch_cnt increments by 1.
5. Mid-qualification reset: sig_raw 0->1, assert rst at edge 4 for 1 cycle, keep sig_raw=1 -> sig_clean=0 through reset; sig_clean rises 6 edges after rst deasserts.
6. Saturation (macro on): force 300 aborted qualifications -> glitch_cnt holds 255; sig_clean unchanged at 0 throughout.
